// File: rtl/podule_pkg.sv
// Shared types and constants for the podule bus front end.
// Region indices below are the default card map.
package podule_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ACK,
    RELEASE
  } bus_state_e;

  localparam int IDX_ECONET   = 0;
  localparam int IDX_IDE      = 1;
  localparam int IDX_IDE2     = 2;
  localparam int IDX_IRQ_STAT = 3;
  localparam int IDX_FPL      = 4;
  localparam int IDX_UART     = 5;
  localparam int IDX_ETH      = 6;
  localparam int IDX_IRQ_MASK = 7;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/podule_bus_seq_if.sv
// Podule bus request/acknowledge bundle.
// The host side is the master, the card front end the slave.
interface podule_bus_seq_if #(
  parameter int AW = 12
);
  logic [AW-1:0] a;
  logic          req;
  logic          we;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          ack;

  modport master (
    output a, req, we, wdata,
    input  rdata, ack
  );

  modport slave (
    input  a, req, we, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/podule_irq_ctl.sv
// Interrupt edge detect, sticky status, mask and card irq.
// Status set beats a same-cycle write-1-to-clear.
module podule_irq_ctl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic             stat_clr,
  input  logic [N_IRQ-1:0] wd,
  output logic [N_IRQ-1:0] status,
  output logic [N_IRQ-1:0] mask,
  output logic             irq_out
);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] irq_h;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;

  assign rise = irq_q & ~irq_h;
  assign clr  = stat_clr ? wd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      irq_h   <= '0;
      status  <= '0;
      mask    <= '0;
      irq_out <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      irq_h   <= irq_q;
      status  <= (status & ~clr) | rise;
      irq_out <= |(status & mask);
      if (mask_we) begin
        mask <= wd;
      end
    end
  end

endmodule

// File: rtl/podule_bus_seq.sv
// Podule bus sequencer: region decode, wait states, selects, ack,
// flash page latch and interrupt register access.
module podule_bus_seq
  import podule_pkg::*;
#(
  parameter int ADDR_HI  = 13,
  parameter int ADDR_LO  = 2,
  parameter int DEV_BITS = 3,
  parameter logic [WAIT_W-1:0] ROM_WAIT = 4'd2,
  parameter logic [WAIT_W*(2**DEV_BITS)-1:0] DEV_WAIT = 32'h1111_2111,
  parameter int IRQ_STAT_IDX = IDX_IRQ_STAT,
  parameter int PAGE_IDX     = IDX_FPL,
  parameter int IRQ_MASK_IDX = IDX_IRQ_MASK,
  parameter int N_IRQ  = 8,
  parameter int PAGE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  podule_bus_seq_if.slave         bus,
  output logic                    rom_cs,
  output logic [2**DEV_BITS-1:0]  dev_cs,
  output logic [PAGE_W-1:0]       rom_page,
  input  logic [N_IRQ-1:0]        irq_in,
  output logic                    irq_out
);

  localparam int AW   = ADDR_HI - ADDR_LO + 1;
  localparam int NDEV = 2**DEV_BITS;

  typedef logic [DEV_BITS-1:0] idx_t;

  bus_state_e        state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic              load;
  logic              fin;

  logic              rom_q;
  idx_t              idx_q;
  logic              we_q;
  logic [7:0]        wd_q;

  logic              in_rom;
  idx_t              in_idx;
  logic [WAIT_W-1:0] in_wait;

  logic              sel_on;
  logic              sel_rom;
  idx_t              sel_idx;
  logic              sel_int;

  logic              rom_cs_n;
  logic [NDEV-1:0]   dev_cs_n;
  logic              ack_q;
  logic [7:0]        rdata_q, rdata_n;

  logic              hit_page, hit_mask, hit_stat;
  logic              mask_we, stat_clr;
  logic [N_IRQ-1:0]  status, mask;

  logic              unused_a;

  assign unused_a = ^bus.a[AW-DEV_BITS-2:0];

  function automatic logic is_int(idx_t i);
    return (i == idx_t'(PAGE_IDX)) ||
           (i == idx_t'(IRQ_MASK_IDX)) ||
           (i == idx_t'(IRQ_STAT_IDX));
  endfunction

  assign in_rom  = ~bus.a[AW-1];
  assign in_idx  = bus.a[AW-2 -: DEV_BITS];
  assign in_wait = in_rom ? ROM_WAIT
                          : DEV_WAIT[{in_idx, 2'b00} +: WAIT_W];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          state_n = ACTIVE;
          cnt_n   = in_wait;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt == '0) begin
          state_n = ACK;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACK: begin
        state_n = RELEASE;
      end
      RELEASE: begin
        if (!bus.req) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // selects are computed for the next cycle so they leave a flop
  assign fin     = (state == ACTIVE) && (cnt == '0);
  assign sel_on  = (state_n == ACTIVE) || (state_n == ACK);
  assign sel_rom = load ? in_rom : rom_q;
  assign sel_idx = load ? in_idx : idx_q;
  assign sel_int = is_int(sel_idx);

  assign rom_cs_n = sel_on & sel_rom;
  assign dev_cs_n = (sel_on && !sel_rom && !sel_int)
                  ? (NDEV'(1) << sel_idx) : '0;

  assign hit_page = fin && !rom_q && (idx_q == idx_t'(PAGE_IDX));
  assign hit_mask = fin && !rom_q && (idx_q == idx_t'(IRQ_MASK_IDX));
  assign hit_stat = fin && !rom_q && (idx_q == idx_t'(IRQ_STAT_IDX));

  assign mask_we  = hit_mask & we_q;
  assign stat_clr = hit_stat & we_q;

  always_comb begin
    rdata_n = '0;
    unique case (1'b1)
      hit_page && !we_q: rdata_n = 8'(rom_page);
      hit_mask && !we_q: rdata_n = 8'(mask);
      hit_stat && !we_q: rdata_n = 8'(status);
      default:           rdata_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rom_q    <= 1'b0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wd_q     <= '0;
      rom_cs   <= 1'b0;
      dev_cs   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      rom_page <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rom_cs  <= rom_cs_n;
      dev_cs  <= dev_cs_n;
      ack_q   <= fin;
      rdata_q <= rdata_n;
      if (load) begin
        rom_q <= in_rom;
        idx_q <= in_idx;
        we_q  <= bus.we;
        wd_q  <= bus.wdata;
      end
      if (hit_page && we_q) begin
        rom_page <= wd_q[PAGE_W-1:0];
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

  podule_irq_ctl #(
    .N_IRQ (N_IRQ)
  ) u_irq (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask_we  (mask_we),
    .stat_clr (stat_clr),
    .wd       (wd_q[N_IRQ-1:0]),
    .status   (status),
    .mask     (mask),
    .irq_out  (irq_out)
  );

endmodule
